upsample_seq: RTL

//  Sequential nearest-neighbour upsampler (factor N), the expansion counterpart of the maxpool stage.

---
 rtl/wvcnn_pkg.sv | 16 +
 rtl/upsample_seq_if.sv | 24 ++
 rtl/upsample_seq_cyc_cnt.sv | 40 ++++
 rtl/upsample_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/wvcnn_pkg.sv
// Shared WVCNN datapath types: default sample width, FSM states, and
// the cyclic-counter width helper reused by the pooling/upsampling stages.
package wvcnn_pkg;

    localparam int DEF_BIT_WIDTH = 12;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/upsample_seq_if.sv
// Sample stream bundle for upsample_seq: strobed input, one-per-cycle
// output, pending-slot status and sticky overflow.
interface upsample_seq_if #(
    parameter int BIT_WIDTH = 12
);

    logic                 in_enable;
    logic [BIT_WIDTH-1:0] data_in;
    logic                 in_ready;
    logic                 out_enable;
    logic [BIT_WIDTH-1:0] data_out;
    logic                 overflow;

    modport master (
        output in_enable, data_in,
        input  in_ready, out_enable, data_out, overflow
    );

    modport slave (
        input  in_enable, data_in,
        output in_ready, out_enable, data_out, overflow
    );

endinterface

// File: rtl/upsample_seq_cyc_cnt.sv
// cyc_cnt: 0..N-1 cyclic counter with enable, load-to-zero and last flag.
// It saturates at N-1; only clr_i brings it back to zero.
module cyc_cnt
    import wvcnn_pkg::*;
#(
    parameter int N    = 3,
    parameter int INIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic last_o
);

    localparam int CW = cnt_w(N);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == CW'(N - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/upsample_seq.sv
// Sequential nearest-neighbour upsampler: each sample repeated N cycles.
// Define UPSAMPLE_ZERO_INSERT_EN for zero-stuffing of copies 1..N-1.
module upsample_seq
    import wvcnn_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int N         = 3
) (
    input  logic           clk,
    input  logic           rst,
    upsample_seq_if.slave  bus
);

`ifdef UPSAMPLE_ZERO_INSERT_EN
    localparam bit ZERO_INS = 1'b1;
`else
    localparam bit ZERO_INS = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] hold_q, hold_d;
    logic [BIT_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 ovf_q, ovf_d;
    logic                 out_en_q, out_en_d;
    logic [BIT_WIDTH-1:0] dout_q, dout_d;
    logic                 load;
    logic                 inc;
    logic                 last;

    cyc_cnt #(
        .N    (N),
        .INIT (0)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (inc),
        .clr_i  (load),
        .last_o (last)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_enable) begin
                    state_d = EMIT;
                    hold_d  = bus.data_in;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (last) begin
                    if (pend_v_q) begin
                        hold_d = pend_q;
                        load   = 1'b1;
                        if (bus.in_enable) begin
                            pend_d = bus.data_in;
                        end else begin
                            pend_v_d = 1'b0;
                        end
                    end else if (bus.in_enable) begin
                        hold_d = bus.data_in;
                        load   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    inc = 1'b1;
                    if (bus.in_enable) begin
                        if (pend_v_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            pend_d   = bus.data_in;
                            pend_v_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A non-load emitting cycle is copy 1..N-1 of the current hold value.
    always_comb begin
        out_en_d = (state_d == EMIT);
        dout_d   = '0;
        if (out_en_d && !(ZERO_INS && !load)) begin
            dout_d = hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
            out_en_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
            out_en_q <= out_en_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.in_ready   = !pend_v_q;
    assign bus.out_enable = out_en_q;
    assign bus.data_out   = dout_q;
    assign bus.overflow   = ovf_q;

endmodule
